// File: rtl/koa_mult_stream_ctrl_if.sv
// Signal bundle between the KOA multiplier stream controller and its environment:
// 32-bit input stream, 32-bit output stream and the multiplier operand/product bus.
interface koa_mult_stream_ctrl_if #(
    parameter int WORD_W = 32,
    parameter int OP_W   = 128
);
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    logic [OP_W-1:0]   mul_a;
    logic [OP_W-1:0]   mul_b;
    logic [2*OP_W-1:0] mul_product;

    logic [WORD_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    logic              busy;

    // Controller side.
    modport slave (
        input  s_data, s_valid, mul_product, m_ready,
        output s_ready, mul_a, mul_b, m_data, m_valid, m_last, busy
    );

    // Environment side: upstream source, downstream sink and the multiplier itself.
    modport master (
        output s_data, s_valid, mul_product, m_ready,
        input  s_ready, mul_a, mul_b, m_data, m_valid, m_last, busy
    );
endinterface

// File: rtl/koa_mult_stream_ctrl.sv
// Stream front/back end for the combinational 128x128 KOA multiplier: gathers A/B from
// a word stream, latches the 256-bit product and serialises it low word first.
module koa_mult_stream_ctrl #(
    parameter int WORD_W = 32,
    parameter int OP_W   = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    koa_mult_stream_ctrl_if.slave bus
);
    localparam int N_IN  = 2 * OP_W / WORD_W;
    localparam int N_OUT = 2 * OP_W / WORD_W;
    localparam int N_OP  = OP_W / WORD_W;
    localparam int CNT_W = $clog2(N_IN);

    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(N_IN - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(N_OUT - 1);
    localparam logic [CNT_W-1:0] A_WORDS  = CNT_W'(N_OP);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        CAPTURE = 2'd1,
        SEND    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [OP_W-1:0]    op_a_q, op_a_d;
    logic [OP_W-1:0]    op_b_q, op_b_d;
    logic [2*OP_W-1:0]  prod_q, prod_d;

    logic              s_ready;
    logic              m_valid;
    logic              m_last;
    logic [WORD_W-1:0] m_data;
    logic              busy;
    logic              s_fire;
    logic              m_fire;

    assign s_fire = bus.s_valid & s_ready;
    assign m_fire = m_valid & bus.m_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (s_fire && in_cnt_q == IN_LAST)  state_d = CAPTURE;
            CAPTURE: state_d = SEND;
            SEND:    if (m_fire && out_cnt_q == OUT_LAST) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Outputs depend on registered state only, so s_ready has no path from s_valid/m_ready.
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        busy    = 1'b0;
        case (state_q)
            LOAD: begin
                s_ready = 1'b1;
            end
            CAPTURE: begin
                busy = 1'b1;
            end
            SEND: begin
                busy    = 1'b1;
                m_valid = 1'b1;
                m_last  = (out_cnt_q == OUT_LAST);
                m_data  = prod_q[WORD_W*32'(out_cnt_q) +: WORD_W];
            end
            default: ;
        endcase
    end

    // Datapath next values: operand word steering, product capture, output word counter.
    always_comb begin
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        prod_d    = prod_q;

        if (s_fire) begin
            in_cnt_d = (in_cnt_q == IN_LAST) ? '0 : in_cnt_q + 1'b1;
            if (in_cnt_q < A_WORDS) begin
                op_a_d[WORD_W*32'(in_cnt_q) +: WORD_W] = bus.s_data;
            end else begin
                op_b_d[WORD_W*32'(in_cnt_q - A_WORDS) +: WORD_W] = bus.s_data;
            end
        end

        // Operands have been stable since the last input transfer, so the
        // combinational product is settled by the end of the capture cycle.
        if (state_q == CAPTURE) begin
            prod_d = bus.mul_product;
        end

        if (m_fire) begin
            out_cnt_d = (out_cnt_q == OUT_LAST) ? '0 : out_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            prod_q    <= '0;
        end else begin
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            prod_q    <= prod_d;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid;
    assign bus.m_last  = m_last;
    assign bus.m_data  = m_data;
    assign bus.busy    = busy;
    assign bus.mul_a   = op_a_q;
    assign bus.mul_b   = op_b_q;
endmodule

// File: tb/tb_koa_mult_stream_ctrl.sv
// Bench for koa_mult_stream_ctrl: the multiplier is modelled as plain 256-bit arithmetic,
// expected product words come from a table or from a*b of the randomly generated operands.
module tb_koa_mult_stream_ctrl;
    localparam int WORD_W = 32;
    localparam int OP_W   = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    koa_mult_stream_ctrl_if #(.WORD_W(WORD_W), .OP_W(OP_W)) bus ();

    koa_mult_stream_ctrl #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [255:0] mul256(input logic [127:0] a, input logic [127:0] b);
        logic [255:0] wa;
        logic [255:0] wb;
        wa = {128'b0, a};
        wb = {128'b0, b};
        return wa * wb;
    endfunction

    assign bus.mul_product = mul256(bus.mul_a, bus.mul_b);

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered and left just after a negedge; ends in the CAPTURE cycle.
    task automatic send_op(input logic [127:0] a, input logic [127:0] b, input int gap_pct,
                           input bit hold, input logic [31:0] hold_word);
        logic [255:0] words;
        bit xfer;
        int t;
        words = {b, a};
        for (int i = 0; i < 8; i++) begin
            t = 0;
            do begin
                if ($urandom_range(99) < gap_pct) begin
                    bus.s_valid = 1'b0;
                    bus.s_data  = $urandom;
                end else begin
                    bus.s_valid = 1'b1;
                    bus.s_data  = words[32*i +: 32];
                end
                xfer = bus.s_valid && bus.s_ready;
                @(negedge clk);
                t++;
                if (t > 200) begin
                    check("send_timeout", 1, 0);
                    return;
                end
            end while (!xfer);
        end
        bus.s_valid = hold;
        bus.s_data  = hold ? hold_word : 32'h0;
        check("capture_hs", {bus.s_ready, bus.m_valid, bus.busy}, 3'b001);
        check("capture_mul_a", bus.mul_a, a);
        check("capture_mul_b", bus.mul_b, b);
    endtask

    // Entered in the CAPTURE cycle; collects n_words words and returns just after a negedge.
    task automatic recv_op(input logic [255:0] exp, input int stall_pct, input int n_words);
        logic [33:0] held;
        bit stalled;
        bit xfer;
        int i;
        int t;
        stalled = 0;
        i = 0;
        t = 0;
        @(negedge clk);
        check("latency_m_valid", bus.m_valid, 1);
        while (i < n_words) begin
            if (stalled) check("stall_hold", {bus.m_valid, bus.m_last, bus.m_data}, held);
            check("s_ready_in_send", bus.s_ready, 0);
            bus.m_ready = ($urandom_range(99) >= stall_pct);
            xfer = bus.m_valid && bus.m_ready;
            if (xfer) begin
                check($sformatf("word%0d", i), bus.m_data, exp[32*i +: 32]);
                check($sformatf("last%0d", i), bus.m_last, (i == 7));
                i++;
                stalled = 0;
            end else begin
                stalled = bus.m_valid;
                held = {bus.m_valid, bus.m_last, bus.m_data};
            end
            @(negedge clk);
            t++;
            if (t > 500) begin
                check("recv_timeout", 1, 0);
                return;
            end
        end
        bus.m_ready = 1'b0;
        if (n_words == 8) check("back_to_load", {bus.s_ready, bus.m_valid, bus.busy}, 3'b100);
    endtask

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic [255:0] exp;
        int           gap_pct;
        int           stall_pct;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] a2;
        logic [127:0] b2;

        vecs[0] = '{128'd1, 128'd1, 256'd1, 0, 0};
        vecs[1] = '{{128{1'b1}}, {128{1'b1}},
                    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_00000000_00000000_00000000_00000001, 20, 30};
        vecs[2] = '{128'd1 << 64, 128'd1 << 64, 256'd1 << 128, 0, 50};
        vecs[3] = '{128'h1_00000000, 128'hFFFFFFFF, 256'hFFFFFFFF_00000000, 40, 70};

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hs", {bus.s_ready, bus.m_valid, bus.m_last, bus.busy}, 4'b1000);
        check("rst_m_data", bus.m_data, 0);
        check("rst_mul", {bus.mul_a, bus.mul_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[k]) begin
            send_op(vecs[k].a, vecs[k].b, vecs[k].gap_pct, 0, 32'h0);
            recv_op(vecs[k].exp, vecs[k].stall_pct, 8);
        end

        // Randomized operands with a sparse-word mix, reference product by plain multiplication.
        for (int r = 0; r < 20; r++) begin
            for (int w = 0; w < 4; w++) begin
                a[32*w +: 32] = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
                b[32*w +: 32] = ($urandom_range(3) == 0) ? 32'hFFFFFFFF : $urandom;
            end
            send_op(a, b, $urandom_range(50), 0, 32'h0);
            recv_op(mul256(a, b), $urandom_range(60), 8);
        end

        // s_valid held high with the next operation's first word through CAPTURE/SEND.
        a  = {$urandom, $urandom, $urandom, $urandom};
        b  = {$urandom, $urandom, $urandom, $urandom};
        a2 = {$urandom, $urandom, $urandom, $urandom};
        b2 = {$urandom, $urandom, $urandom, $urandom};
        send_op(a, b, 0, 1, a2[31:0]);
        recv_op(mul256(a, b), 30, 8);
        send_op(a2, b2, 0, 0, 32'h0);
        recv_op(mul256(a2, b2), 0, 8);

        // Reset in the middle of SEND discards the remaining words.
        send_op(128'h1234_5678, 128'h9ABC_DEF0, 0, 0, 32'h0);
        recv_op(mul256(128'h1234_5678, 128'h9ABC_DEF0), 0, 3);
        rst_n = 1'b0;
        #1;
        check("midrst_hs", {bus.s_ready, bus.m_valid, bus.m_last, bus.busy}, 4'b1000);
        check("midrst_mul", {bus.mul_a, bus.mul_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_op(128'd3, 128'd5, 0, 0, 32'h0);
        recv_op(256'h0F, 20, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
